// File: rtl/tlc_pkg.sv
// Shared lamp/walk codes, FSM state encoding and default phase durations for the traffic-light controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package tlc_pkg;

    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b100;

    localparam logic [1:0] PED_NONE = 2'b00;
    localparam logic [1:0] PED_NS   = 2'b01;
    localparam logic [1:0] PED_EW   = 2'b10;
    localparam logic [1:0] PED_BOTH = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PED,
        ST_NS_GREEN,
        ST_NS_YELLOW,
        ST_EW_GREEN,
        ST_EW_YELLOW
    } state_t;

    typedef enum logic {
        LG_NS,
        LG_EW
    } green_t;

    localparam int DEF_DIV_AMT     = 10;
    localparam int DEF_N           = 4;
    localparam int DEF_PED_TIME    = 15;
    localparam int DEF_GREEN_TIME  = 10;
    localparam int DEF_YELLOW_TIME = 5;

endpackage

// File: rtl/tlc_tick_timer.sv
// Prescaler emitting a one-cycle tick every DIV_AMT clocks, plus a loadable saturating countdown.
// Latency: load and decrement take effect on the next clock edge.
// Backpressure: none; free-running.
module tlc_tick_timer
    import tlc_pkg::*;
#(
    parameter int DIV_AMT = DEF_DIV_AMT,
    parameter int N       = DEF_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] init,
    output logic         tick,
    output logic [N-1:0] out
);

    localparam int CW = (DIV_AMT > 1) ? $clog2(DIV_AMT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  out_q, out_d;

    always_comb begin
        tick  = (cnt_q == CW'(DIV_AMT - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        out_d = out_q;
        // load wins over a coincident tick so a fresh phase never loses its first step
        if (load) begin
            out_d = init;
        end else if (en && tick && (out_q != '0)) begin
            out_d = out_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/tlc_system.sv
// Traffic-light controller for one NS/EW intersection with pedestrian phase; optional ped latch via TLC_PED_LATCH_EN.
// Latency: lamps are Moore outputs of the state register; phase changes on tick edges.
// Backpressure: none; sensor and button inputs are sampled levels.
module tlc_system
    import tlc_pkg::*;
#(
    parameter int DIV_AMT     = DEF_DIV_AMT,
    parameter int N           = DEF_N,
    parameter int PED_TIME    = DEF_PED_TIME,
    parameter int GREEN_TIME  = DEF_GREEN_TIME,
    parameter int YELLOW_TIME = DEF_YELLOW_TIME
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         car_ns,
    input  logic         car_ew,
    input  logic         ped,
    output logic [2:0]   light_ns,
    output logic [2:0]   light_ew,
    output logic [1:0]   light_ped,
    output logic [N-1:0] timer_out
);

    localparam logic [N-1:0] PED_INIT    = N'(PED_TIME - 1);
    localparam logic [N-1:0] GREEN_INIT  = N'(GREEN_TIME - 1);
    localparam logic [N-1:0] YELLOW_INIT = N'(YELLOW_TIME - 1);

    state_t       state_q, state_d;
    green_t       last_green_q, last_green_d;
    logic         load_q, load_d;
    logic         tick;
    logic         timer_en;
    logic [N-1:0] timer_init;
    logic         expire;
    logic         ped_eff;

    tlc_tick_timer #(
        .DIV_AMT (DIV_AMT),
        .N       (N)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (timer_en),
        .load (load_q),
        .init (timer_init),
        .tick (tick),
        .out  (timer_out)
    );

    // the load cycle masks expiry while the timer still holds the previous phase's zero
    assign expire = tick && (timer_out == '0) && !load_q;

`ifdef TLC_PED_LATCH_EN
    logic ped_prev_q, ped_latch_q, ped_latch_d, ped_rise;

    assign ped_rise = ped && !ped_prev_q && (state_q != ST_IDLE) && (state_q != ST_PED);
    assign ped_eff  = ped_latch_q || ped_rise;

    always_comb begin
        ped_latch_d = ped_latch_q || ped_rise;
        if ((state_d == ST_PED) && (state_q != ST_PED)) begin
            ped_latch_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_prev_q  <= 1'b0;
            ped_latch_q <= 1'b0;
        end else begin
            ped_prev_q  <= ped;
            ped_latch_q <= ped_latch_d;
        end
    end
`else
    assign ped_eff = ped;
`endif

    always_comb begin
        state_d      = state_q;
        last_green_d = last_green_q;
        load_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_PED;
                load_d  = 1'b1;
            end
            ST_PED: if (expire) begin
                load_d = 1'b1;
                if (last_green_q == LG_EW) begin
                    state_d      = ST_NS_GREEN;
                    last_green_d = LG_NS;
                end else begin
                    state_d      = ST_EW_GREEN;
                    last_green_d = LG_EW;
                end
            end
            ST_NS_GREEN: if (expire) begin
                load_d = 1'b1;
                if (!(car_ns && !car_ew && !ped_eff)) state_d = ST_NS_YELLOW;
            end
            ST_NS_YELLOW: if (expire) begin
                load_d = 1'b1;
                if (ped_eff) begin
                    state_d = ST_PED;
                end else begin
                    state_d      = ST_EW_GREEN;
                    last_green_d = LG_EW;
                end
            end
            ST_EW_GREEN: if (expire) begin
                load_d = 1'b1;
                if (!(car_ew && !car_ns && !ped_eff)) state_d = ST_EW_YELLOW;
            end
            ST_EW_YELLOW: if (expire) begin
                load_d = 1'b1;
                if (ped_eff) begin
                    state_d = ST_PED;
                end else begin
                    state_d      = ST_NS_GREEN;
                    last_green_d = LG_NS;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        light_ns   = LIGHT_RED;
        light_ew   = LIGHT_RED;
        light_ped  = PED_NONE;
        timer_en   = (state_q != ST_IDLE);
        timer_init = '0;
        case (state_q)
            ST_PED: begin
                light_ped  = PED_BOTH;
                timer_init = PED_INIT;
            end
            ST_NS_GREEN: begin
                light_ns   = LIGHT_GREEN;
                light_ped  = PED_NS;
                timer_init = GREEN_INIT;
            end
            ST_NS_YELLOW: begin
                light_ns   = LIGHT_YELLOW;
                light_ped  = PED_NS;
                timer_init = YELLOW_INIT;
            end
            ST_EW_GREEN: begin
                light_ew   = LIGHT_GREEN;
                light_ped  = PED_EW;
                timer_init = GREEN_INIT;
            end
            ST_EW_YELLOW: begin
                light_ew   = LIGHT_YELLOW;
                light_ped  = PED_EW;
                timer_init = YELLOW_INIT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_green_q <= LG_EW;
            load_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_green_q <= last_green_d;
            load_q       <= load_d;
        end
    end

endmodule

// File: tb/tb_tlc_system.sv
// Bench for tlc_system: phase-schedule model (entry edge -> exit edge arithmetic) checked every cycle,
// plus directed literal checks for the main sequences, extension, ped phase and async reset.
module tb_tlc_system;

    localparam int DIV = 10;
    localparam int NW  = 4;
    localparam int PT  = 15;
    localparam int GT  = 10;
    localparam int YT  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          car_ns = 1'b0;
    logic          car_ew = 1'b0;
    logic          ped = 1'b0;
    logic [2:0]    light_ns, light_ew;
    logic [1:0]    light_ped;
    logic [NW-1:0] timer_out;

    always #5 clk = ~clk;

    tlc_system #(
        .DIV_AMT(DIV), .N(NW), .PED_TIME(PT), .GREEN_TIME(GT), .YELLOW_TIME(YT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .car_ns    (car_ns),
        .car_ew    (car_ew),
        .ped       (ped),
        .light_ns  (light_ns),
        .light_ew  (light_ew),
        .light_ped (light_ped),
        .timer_out (timer_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Phases: 0 IDLE, 1 PED, 2 NS green, 3 NS yellow, 4 EW green, 5 EW yellow.
    int dur_of[6] = '{0, PT, GT, YT, GT, YT};
    int exp_ns[6] = '{4, 4, 1, 2, 4, 4};
    int exp_ew[6] = '{4, 4, 4, 4, 1, 2};
    int exp_pd[6] = '{0, 3, 1, 1, 2, 2};

    int k;        // clock edges since reset release
    int m_ph;
    int m_entry;  // edge at which the phase was entered
    int m_exit;   // edge at which the phase expires
    bit m_last_ns;
    bit m_latch;
    bit m_pprev;

    // Entry edge E: timer loaded at E+1, then one decrement per tick edge, exit on the dur-th tick edge after E+1.
    task automatic m_enter(input int ph);
        m_ph    = ph;
        m_entry = k;
        m_exit  = ((k + 1) / DIV + 1) * DIV + (dur_of[ph] - 1) * DIV;
        if (ph == 2) m_last_ns = 1'b1;
        if (ph == 4) m_last_ns = 1'b0;
    endtask

    function automatic int exp_timer();
        int v;
        if (m_ph == 0 || k == m_entry) return 0;
        v = dur_of[m_ph] - 1 - (k / DIV - (m_entry + 1) / DIV);
        return (v < 0) ? 0 : v;
    endfunction

    initial begin
        k = 0; m_ph = 0; m_entry = 0; m_exit = 0;
        m_last_ns = 1'b0; m_latch = 1'b0; m_pprev = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                k = 0; m_ph = 0; m_entry = 0; m_exit = 0;
                m_last_ns = 1'b0; m_latch = 1'b0; m_pprev = 1'b0;
            end else begin : step
                bit pe;
`ifdef TLC_PED_LATCH_EN
                bit rise;
                bit gy;
                gy   = (m_ph >= 2);
                rise = ped && !m_pprev;
                pe   = m_latch || (rise && gy);
`else
                pe = ped;
`endif
                k++;
                if (m_ph == 0) begin
                    m_enter(1);
                end else if (k == m_exit) begin
                    case (m_ph)
                        1: m_enter(m_last_ns ? 4 : 2);
                        2: m_enter((car_ns && !car_ew && !pe) ? 2 : 3);
                        3: m_enter(pe ? 1 : 4);
                        4: m_enter((car_ew && !car_ns && !pe) ? 4 : 5);
                        default: m_enter(pe ? 1 : 2);
                    endcase
                end
`ifdef TLC_PED_LATCH_EN
                if (m_ph == 1 && m_entry == k) m_latch = 1'b0;
                else if (rise && gy)           m_latch = 1'b1;
                m_pprev = ped;
`endif
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("model_ns",    int'(light_ns),  exp_ns[m_ph]);
                chk("model_ew",    int'(light_ew),  exp_ew[m_ph]);
                chk("model_walk",  int'(light_ped), exp_pd[m_ph]);
                chk("model_timer", int'(timer_out), exp_timer());
            end
        end
    end

    task automatic wait_k(input int n);
        int guard = 0;
        while (k < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (k < n) chk("wait_timeout", k, n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ns",    int'(light_ns),  4);
        chk("reset_ew",    int'(light_ew),  4);
        chk("reset_walk",  int'(light_ped), 0);
        chk("reset_timer", int'(timer_out), 0);
        rst = 1'b0;

        // all inputs idle: PED, NS green, NS yellow, EW green, EW yellow, straight back to NS green
        wait_k(20);  chk("ped_walk", int'(light_ped), 3); chk("ped_ns", int'(light_ns), 4);
        wait_k(155); chk("nsg_ns", int'(light_ns), 1); chk("nsg_walk", int'(light_ped), 1);
                     chk("nsg_timer", int'(timer_out), 9);
        wait_k(160); chk("nsg_timer_step", int'(timer_out), 8);
        wait_k(251); chk("nsy_ns", int'(light_ns), 2);
        wait_k(301); chk("ewg_ew", int'(light_ew), 1); chk("ewg_walk", int'(light_ped), 2);
        wait_k(451); chk("no_ped_nsg", int'(light_ns), 1); chk("no_ped_walk", int'(light_ped), 1);

        // NS green extension while only NS has cars, ended by an EW car
        do_reset();
        car_ns = 1'b1;
        wait_k(260); chk("ext_still_green", int'(light_ns), 1);
        wait_k(300); car_ew = 1'b1;
        wait_k(351); chk("ext_end_yellow", int'(light_ns), 2);
        car_ns = 1'b0; car_ew = 1'b0;

        // pedestrian raised during NS green -> PED after NS yellow -> EW green
        do_reset();
        wait_k(200); ped = 1'b1;
        wait_k(301); chk("req_ped_walk", int'(light_ped), 3); chk("req_ped_ns", int'(light_ns), 4);
        wait_k(451); chk("after_ped_ew", int'(light_ew), 1); chk("after_ped_walk", int'(light_ped), 2);
        ped = 1'b0;

        // asynchronous reset in the middle of EW green
        wait_k(500);
        chk("pre_rst_ew", int'(light_ew), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ns",    int'(light_ns),  4);
        chk("arst_ew",    int'(light_ew),  4);
        chk("arst_walk",  int'(light_ped), 0);
        chk("arst_timer", int'(timer_out), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_k(20);  chk("restart_ped", int'(light_ped), 3);
        wait_k(155); chk("restart_nsg", int'(light_ns), 1);

        // randomized sensor/button traffic against the model
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) car_ns = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) car_ew = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) ped    = 1'($urandom_range(0, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
